// File: rtl/svc_rv_dmem_pkg.sv
// Shared types and helpers for the svc_rv data-memory requester.
// Misaligned-access checking is enabled by defining SVC_RV_DMEM_MISALIGN_EN.
package svc_rv_dmem_pkg;

   localparam logic [2:0] F3_LB  = 3'b000;
   localparam logic [2:0] F3_LH  = 3'b001;
   localparam logic [2:0] F3_LW  = 3'b010;
   localparam logic [2:0] F3_LBU = 3'b100;
   localparam logic [2:0] F3_LHU = 3'b101;
   localparam logic [2:0] F3_SB  = 3'b000;
   localparam logic [2:0] F3_SH  = 3'b001;
   localparam logic [2:0] F3_SW  = 3'b010;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DATA   = 2'd2,
      RESP   = 2'd3
   } state_t;

   function automatic logic [3:0] wstrb_gen(input logic [2:0] funct3,
                                            input logic [1:0] off);
      logic [3:0] strb;
      case (funct3)
         F3_SB:   strb = 4'b0001 << off;
         F3_SH:   strb = 4'b0011 << {off[1], 1'b0};
         F3_SW:   strb = 4'b1111;
         default: strb = 4'b0000;
      endcase
      return strb;
   endfunction

   // Sub-word stores replicate the datum across every lane; wstrb picks the lane.
   function automatic logic [31:0] wdata_gen(input logic [2:0]  funct3,
                                             input logic [31:0] wdata);
      logic [31:0] d;
      case (funct3)
         F3_SB:   d = {4{wdata[7:0]}};
         F3_SH:   d = {2{wdata[15:0]}};
         default: d = wdata;
      endcase
      return d;
   endfunction

   function automatic logic illegal_f3(input logic we, input logic [2:0] funct3);
      logic bad;
      if (we)
         bad = !(funct3 == F3_SB || funct3 == F3_SH || funct3 == F3_SW);
      else
         bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
      return bad;
   endfunction

endpackage

// File: rtl/svc_rv_ld_ext.sv
// Load-data lane extraction and sign/zero extension (combinational).
module svc_rv_ld_ext
   import svc_rv_dmem_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [2:0]  i_funct3,
   input  logic [1:0]  i_off,
   output logic [31:0] o_data
);

   logic [31:0] w_bshift;
   logic [31:0] w_hshift;
   logic [7:0]  w_byte;
   logic [15:0] w_half;

   assign w_bshift = i_rdata >> {i_off, 3'b000};
   assign w_hshift = i_rdata >> {i_off[1], 4'b0000};
   assign w_byte   = w_bshift[7:0];
   assign w_half   = w_hshift[15:0];

   always_comb begin
      o_data = '0;
      case (i_funct3)
         F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
         F3_LBU:  o_data = {24'b0, w_byte};
         F3_LH:   o_data = {{16{w_half[15]}}, w_half};
         F3_LHU:  o_data = {16'b0, w_half};
         F3_LW:   o_data = i_rdata;
         default: o_data = '0;
      endcase
   end

endmodule

// File: rtl/svc_rv_dmem_req.sv
// Core-side data-memory requester: one load/store at a time, SRAM or BRAM latency.
// Define SVC_RV_DMEM_MISALIGN_EN to reject misaligned halfword/word accesses.
module svc_rv_dmem_req
   import svc_rv_dmem_pkg::*;
#(
   parameter int MEM_TYPE = 0,
   parameter int XLEN     = 32
) (
   input  logic            clock,
   input  logic            reset,

   input  logic            i_req_valid,
   output logic            o_req_ready,
   input  logic            i_req_we,
   input  logic [2:0]      i_req_funct3,
   input  logic [XLEN-1:0] i_req_addr,
   input  logic [XLEN-1:0] i_req_wdata,

   output logic            o_rsp_valid,
   input  logic            i_rsp_ready,
   output logic [XLEN-1:0] o_rsp_rdata,
   output logic            o_rsp_err,

   output logic            o_dmem_ren,
   output logic [XLEN-1:0] o_dmem_raddr,
   input  logic [XLEN-1:0] i_dmem_rdata,
   output logic            o_dmem_we,
   output logic [XLEN-1:0] o_dmem_waddr,
   output logic [XLEN-1:0] o_dmem_wdata,
   output logic [3:0]      o_dmem_wstrb,
   input  logic            i_dmem_stall
);

   state_t          r_state;
   state_t          w_next;
   logic            r_we;
   logic [2:0]      r_funct3;
   logic [XLEN-1:0] r_addr;
   logic [XLEN-1:0] r_wdata;
   logic [3:0]      r_wstrb;
   logic [XLEN-1:0] r_rdata;
   logic            r_err;

   logic            w_accept;
   logic            w_misalign;
   logic            w_dec_err;
   logic            w_ren;
   logic            w_we;
   logic            w_rsp_valid;
   logic            w_cap;
   logic [XLEN-1:0] w_ext;
   logic [XLEN-1:0] w_aligned;

`ifdef SVC_RV_DMEM_MISALIGN_EN
   assign w_misalign = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) ||
                       ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
`else
   assign w_misalign = 1'b0;
`endif

   assign w_dec_err = illegal_f3(i_req_we, i_req_funct3) || w_misalign;
   assign w_accept  = (r_state == IDLE) && i_req_valid;
   assign w_aligned = {r_addr[XLEN-1:2], 2'b00};

   svc_rv_ld_ext u_ld_ext (
      .i_rdata  (i_dmem_rdata),
      .i_funct3 (r_funct3),
      .i_off    (r_addr[1:0]),
      .o_data   (w_ext)
   );

   always_ff @(posedge clock) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      w_ren       = 1'b0;
      w_we        = 1'b0;
      w_rsp_valid = 1'b0;
      w_cap       = 1'b0;
      case (r_state)
         IDLE: begin
            if (i_req_valid) w_next = w_dec_err ? RESP : ACCESS;
         end
         ACCESS: begin
            w_ren = !r_we;
            w_we  = r_we;
            // A stalled strobe is simply repeated; only the unstalled one counts.
            if (!i_dmem_stall) begin
               if (r_we || (MEM_TYPE == 0)) w_next = RESP;
               else                         w_next = DATA;
               w_cap = !r_we && (MEM_TYPE == 0);
            end
         end
         DATA: begin
            if (!i_dmem_stall) begin
               w_cap  = 1'b1;
               w_next = RESP;
            end
         end
         RESP: begin
            w_rsp_valid = 1'b1;
            if (i_rsp_ready) w_next = IDLE;
         end
         default: w_next = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         r_we     <= 1'b0;
         r_funct3 <= '0;
         r_addr   <= '0;
         r_wdata  <= '0;
         r_wstrb  <= '0;
         r_rdata  <= '0;
         r_err    <= 1'b0;
      end else if (w_accept) begin
         r_we     <= i_req_we;
         r_funct3 <= i_req_funct3;
         r_addr   <= i_req_addr;
         r_wdata  <= wdata_gen(i_req_funct3, i_req_wdata);
         r_wstrb  <= w_dec_err ? 4'b0000 : wstrb_gen(i_req_funct3, i_req_addr[1:0]);
         r_rdata  <= '0;
         r_err    <= w_dec_err;
      end else if (w_cap) begin
         r_rdata  <= w_ext;
      end
   end

   // Reset masks every output so nothing leaks while the FSM is being cleared.
   assign o_req_ready  = (r_state == IDLE) && !reset;
   assign o_dmem_ren   = w_ren && !reset;
   assign o_dmem_we    = w_we && !reset;
   assign o_rsp_valid  = w_rsp_valid && !reset;
   assign o_dmem_raddr = o_dmem_ren ? w_aligned : '0;
   assign o_dmem_waddr = o_dmem_we  ? w_aligned : '0;
   assign o_dmem_wdata = o_dmem_we  ? r_wdata   : '0;
   assign o_dmem_wstrb = o_dmem_we  ? r_wstrb   : 4'b0000;
   assign o_rsp_rdata  = o_rsp_valid ? r_rdata  : '0;
   assign o_rsp_err    = o_rsp_valid && r_err;

endmodule

// File: tb/tb_svc_rv_dmem_req.sv
// Bench for svc_rv_dmem_req: an SRAM instance and a BRAM instance, each with a memory responder.
module tb_svc_rv_dmem_req;

   logic        clock;
   logic        reset;
   logic        req_valid[2];
   logic        req_ready[2];
   logic        req_we[2];
   logic [2:0]  req_f3[2];
   logic [31:0] req_addr[2];
   logic [31:0] req_wdata[2];
   logic        rsp_valid[2];
   logic        rsp_ready[2];
   logic [31:0] rsp_rdata[2];
   logic        rsp_err[2];
   logic        ren[2];
   logic [31:0] raddr[2];
   logic [31:0] rdata[2];
   logic        wen[2];
   logic [31:0] waddr[2];
   logic [31:0] wdata[2];
   logic [3:0]  wstrb[2];
   logic        stall[2];
   logic [31:0] mem[2][256];

   int n_chk;
   int n_fail;

   initial clock = 1'b0;
   always #5 clock = ~clock;

   for (genvar g = 0; g < 2; g++) begin : g_dut
      svc_rv_dmem_req #(.MEM_TYPE(g), .XLEN(32)) u_dut (
         .clock        (clock),
         .reset        (reset),
         .i_req_valid  (req_valid[g]),
         .o_req_ready  (req_ready[g]),
         .i_req_we     (req_we[g]),
         .i_req_funct3 (req_f3[g]),
         .i_req_addr   (req_addr[g]),
         .i_req_wdata  (req_wdata[g]),
         .o_rsp_valid  (rsp_valid[g]),
         .i_rsp_ready  (rsp_ready[g]),
         .o_rsp_rdata  (rsp_rdata[g]),
         .o_rsp_err    (rsp_err[g]),
         .o_dmem_ren   (ren[g]),
         .o_dmem_raddr (raddr[g]),
         .i_dmem_rdata (rdata[g]),
         .o_dmem_we    (wen[g]),
         .o_dmem_waddr (waddr[g]),
         .o_dmem_wdata (wdata[g]),
         .o_dmem_wstrb (wstrb[g]),
         .i_dmem_stall (stall[g])
      );
      if (g == 0) begin : g_sram
         assign rdata[g] = mem[g][raddr[g][9:2]];
      end else begin : g_bram
         logic [31:0] q;
         always_ff @(posedge clock)
            if (ren[g] && !stall[g]) q <= mem[g][raddr[g][9:2]];
         assign rdata[g] = q;
      end
   end

   typedef struct {
      int          d;
      logic        we;
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      int          s1;
      int          s2;
      int          r;
      logic        err;
      logic [31:0] rd;
      logic [3:0]  ws;
      logic [31:0] wdo;
   } vec_t;

   vec_t tbl[14];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Reference: access size from funct3, lane = offset rounded down to the size.
   task automatic model(input int d, input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        output logic err, output logic [31:0] rd,
                        output logic [3:0] ws, output logic [31:0] wdo);
      int sz, off, eff;
      logic [31:0] v, mask;
      sz  = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
      if (we) err = f3[2] || (f3[1:0] == 2'd3);
      else    err = (f3[1:0] == 2'd3) || (f3[2] && f3[1]);
`ifdef SVC_RV_DMEM_MISALIGN_EN
      if ((a % sz) != 0) err = 1'b1;
`endif
      rd = 0; ws = 0; wdo = 0;
      if (err) return;
      off = int'(a % 4);
      eff = off - (off % sz);
      if (we) begin
         ws = 4'(((1 << sz) - 1) << eff);
         case (sz)
            1:       wdo = (wd & 32'hFF) * 32'h01010101;
            2:       wdo = (wd & 32'hFFFF) * 32'h00010001;
            default: wdo = wd;
         endcase
         for (int b = 0; b < sz; b++)
            mem[d][a[9:2]][8*(eff+b) +: 8] = wd[8*b +: 8];
      end else begin
         v = mem[d][a[9:2]] >> (8 * eff);
         if (sz < 4) begin
            mask = (32'h1 << (8 * sz)) - 32'h1;
            v = v & mask;
            if (!f3[2] && v[8*sz-1]) v = v | ~mask;
         end
         rd = v;
      end
   endtask

   task automatic txn(input int d, input logic we, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] wd,
                      input int s1, input int s2, input int r,
                      input logic e_err, input logic [31:0] e_rd,
                      input logic [3:0] e_ws, input logic [31:0] e_wd);
      int   kr;
      logic bl, strobe, rv;
      bl = (d == 1) && !we && !e_err;
      kr = e_err ? 1 : (bl ? 3 + s1 + s2 : 2 + s1);
      @(posedge clock); #1;
      req_valid[d] = 1'b1; req_we[d] = we; req_f3[d] = f3;
      req_addr[d] = a; req_wdata[d] = wd; stall[d] = 1'b0; rsp_ready[d] = 1'b0;
      #1 chk("req_ready", 32'(req_ready[d]), 32'd1);
      for (int k = 1; k <= kr + r + 1; k++) begin
         @(posedge clock); #1;
         req_valid[d] = 1'b0;
         stall[d] = !e_err && ((k <= s1) || (bl && k > 1 + s1 && k <= 1 + s1 + s2));
         rsp_ready[d] = (k == kr + r);
         #1;
         strobe = !e_err && (k <= 1 + s1);
         rv = (k >= kr) && (k <= kr + r);
         chk("dmem_ren", 32'(ren[d]), 32'(strobe && !we));
         chk("dmem_we", 32'(wen[d]), 32'(strobe && we));
         if (strobe && !we) chk("dmem_raddr", raddr[d], a & 32'hFFFF_FFFC);
         if (strobe && we) begin
            chk("dmem_waddr", waddr[d], a & 32'hFFFF_FFFC);
            chk("dmem_wstrb", 32'(wstrb[d]), 32'(e_ws));
            chk("dmem_wdata", wdata[d], e_wd);
         end
         chk("rsp_valid", 32'(rsp_valid[d]), 32'(rv));
         if (rv) begin
            chk("rsp_rdata", rsp_rdata[d], e_rd);
            chk("rsp_err", 32'(rsp_err[d]), 32'(e_err));
         end
         if (k == kr + r + 1) chk("req_ready_after", 32'(req_ready[d]), 32'd1);
      end
      rsp_ready[d] = 1'b0;
   endtask

   initial begin
      logic        m_err;
      logic [31:0] m_rd, m_wdo;
      logic [3:0]  m_ws;
      n_chk = 0; n_fail = 0;
      reset = 1'b1;
      for (int d = 0; d < 2; d++) begin
         req_valid[d] = 0; req_we[d] = 0; req_f3[d] = 0; req_addr[d] = 0;
         req_wdata[d] = 0; rsp_ready[d] = 0; stall[d] = 0;
         for (int i = 0; i < 256; i++) mem[d][i] = $urandom;
      end
      mem[0][8'h40] = 32'hDEADBEEF;
      mem[1][8'h40] = 32'h80000000;

      repeat (3) @(posedge clock);
      #2;
      for (int d = 0; d < 2; d++) begin
         chk("rst_req_ready", 32'(req_ready[d]), 32'd0);
         chk("rst_ren", 32'(ren[d]), 32'd0);
         chk("rst_we", 32'(wen[d]), 32'd0);
         chk("rst_rsp_valid", 32'(rsp_valid[d]), 32'd0);
         chk("rst_rsp_rdata", rsp_rdata[d], 32'd0);
      end
      @(posedge clock); #1 reset = 1'b0;

      tbl[0]  = '{0, 1'b0, 3'b010, 32'h100, 32'h0,        0, 0, 0, 1'b0, 32'hDEADBEEF, 4'h0, 32'h0};
      tbl[1]  = '{1, 1'b0, 3'b000, 32'h103, 32'h0,        0, 0, 0, 1'b0, 32'hFFFFFF80, 4'h0, 32'h0};
      tbl[2]  = '{1, 1'b0, 3'b100, 32'h103, 32'h0,        0, 0, 0, 1'b0, 32'h00000080, 4'h0, 32'h0};
      tbl[3]  = '{0, 1'b1, 3'b001, 32'h102, 32'h1234,     0, 0, 0, 1'b0, 32'h0, 4'b1100, 32'h12341234};
      tbl[4]  = '{0, 1'b1, 3'b010, 32'h104, 32'hCAFEF00D, 2, 0, 2, 1'b0, 32'h0, 4'b1111, 32'hCAFEF00D};
`ifdef SVC_RV_DMEM_MISALIGN_EN
      tbl[5]  = '{1, 1'b0, 3'b010, 32'h101, 32'h0,        0, 0, 0, 1'b1, 32'h0, 4'h0, 32'h0};
      tbl[6]  = '{1, 1'b0, 3'b001, 32'h103, 32'h0,        0, 0, 1, 1'b1, 32'h0, 4'h0, 32'h0};
`else
      tbl[5]  = '{1, 1'b0, 3'b010, 32'h101, 32'h0,        0, 0, 0, 1'b0, 32'h80000000, 4'h0, 32'h0};
      tbl[6]  = '{1, 1'b0, 3'b001, 32'h103, 32'h0,        0, 0, 1, 1'b0, 32'hFFFF8000, 4'h0, 32'h0};
`endif
      tbl[7]  = '{0, 1'b0, 3'b011, 32'h200, 32'h0,        0, 0, 1, 1'b1, 32'h0, 4'h0, 32'h0};
      tbl[8]  = '{0, 1'b1, 3'b101, 32'h200, 32'h55,       0, 0, 0, 1'b1, 32'h0, 4'h0, 32'h0};
      tbl[9]  = '{1, 1'b0, 3'b111, 32'h200, 32'h0,        0, 0, 0, 1'b1, 32'h0, 4'h0, 32'h0};
      tbl[10] = '{1, 1'b0, 3'b001, 32'h102, 32'h0,        1, 2, 0, 1'b0, 32'hFFFF8000, 4'h0, 32'h0};
      tbl[11] = '{1, 1'b0, 3'b101, 32'h102, 32'h0,        0, 1, 1, 1'b0, 32'h00008000, 4'h0, 32'h0};
      tbl[12] = '{0, 1'b1, 3'b000, 32'h101, 32'hAB,       0, 0, 0, 1'b0, 32'h0, 4'b0010, 32'hABABABAB};
      tbl[13] = '{0, 1'b0, 3'b000, 32'h101, 32'h0,        1, 0, 0, 1'b0, 32'hFFFFFFAB, 4'h0, 32'h0};

      for (int i = 0; i < 14; i++) begin
         txn(tbl[i].d, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd,
             tbl[i].s1, tbl[i].s2, tbl[i].r, tbl[i].err, tbl[i].rd, tbl[i].ws, tbl[i].wdo);
         if (tbl[i].we && !tbl[i].err)
            model(tbl[i].d, tbl[i].we, tbl[i].f3, tbl[i].addr, tbl[i].wd, m_err, m_rd, m_ws, m_wdo);
      end

      // Reset lands while the BRAM load strobe is on the bus.
      @(posedge clock); #1;
      req_valid[1] = 1'b1; req_we[1] = 1'b0; req_f3[1] = 3'b010; req_addr[1] = 32'h100;
      @(posedge clock); #1;
      req_valid[1] = 1'b0;
      #1 chk("pre_reset_ren", 32'(ren[1]), 32'd1);
      reset = 1'b1;
      #1 chk("in_reset_req_ready", 32'(req_ready[1]), 32'd0);
      @(posedge clock); #1;
      reset = 1'b0;
      #1;
      chk("post_reset_ren", 32'(ren[1]), 32'd0);
      chk("post_reset_we", 32'(wen[1]), 32'd0);
      chk("post_reset_rsp_valid", 32'(rsp_valid[1]), 32'd0);
      chk("post_reset_req_ready", 32'(req_ready[1]), 32'd1);
      model(1, 1'b0, 3'b010, 32'h104, 32'h0, m_err, m_rd, m_ws, m_wdo);
      txn(1, 1'b0, 3'b010, 32'h104, 32'h0, 0, 0, 0, m_err, m_rd, m_ws, m_wdo);

      for (int i = 0; i < 200; i++) begin
         int          d, s1, s2, r;
         logic        we;
         logic [2:0]  f3;
         logic [31:0] a, wd;
         d  = i % 2;
         we = 1'($urandom);
         f3 = 3'($urandom);
         a  = $urandom_range(0, 1023);
         wd = $urandom;
         s1 = $urandom_range(0, 2);
         s2 = $urandom_range(0, 2);
         r  = $urandom_range(0, 2);
         model(d, we, f3, a, wd, m_err, m_rd, m_ws, m_wdo);
         txn(d, we, f3, a, wd, s1, s2, r, m_err, m_rd, m_ws, m_wdo);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/svc_rv_dmem_req.md
# svc_rv_dmem_req

Core-side data-memory requester for the svc_rv pipeline: accepts one load/store micro-op at a time over a valid/ready handshake. Drives the `dmem_*` read/write port and honours `dmem_stall` and SRAM/BRAM read latency. Returns aligned, sign/zero-extended load data, or a store completion, over a response handshake. It is the initiator that the core's memory responders answer.

## Interface
- `MEM_TYPE`, 0: read latency. 0 = SRAM (rdata valid in the strobe cycle); 1 = BRAM (rdata valid the cycle after the strobe).
- `XLEN`, 32: data/address width. Only 32 is supported.
- `clock` in 1: clock. Everything is on the rising edge.
- `reset` in 1: reset, synchronous, active-high.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when high together with `req_valid`.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I load/store funct3.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: response consumed.
- `rsp_rdata` out 32: extended load data. 0 for stores and errors.
- `rsp_err` out 1: illegal funct3, or misaligned access (see Configuration).
- `dmem_ren` out 1: read strobe.
- `dmem_raddr` out 32: word-aligned read address.
- `dmem_rdata` in 32: read data.
- `dmem_we` out 1: write strobe.
- `dmem_waddr` out 32: word-aligned write address.
- `dmem_wdata` out 32: lane-replicated write data.
- `dmem_wstrb` out 4: byte enables.
- `dmem_stall` in 1: memory stall. It extends the current bus cycle.

## Operation
- FSM states are IDLE, ACCESS, DATA and RESP.
- **IDLE**
  - `req_ready` is 1.
  - On `req_valid`: register `req_*`, decode, and go to ACCESS.
  - If the decode error is set, go to RESP with `rsp_err`=1 instead. No bus strobe is issued.
- **ACCESS**
  - Assert `dmem_ren` (load) or `dmem_we` (store) with registered address, data and strobe.
  - While `dmem_stall` is high, stay in ACCESS with all outputs held.
  - When `dmem_stall` is low:
    - Store: go to RESP.
    - Load with MEM_TYPE=0: capture extended `dmem_rdata` and go to RESP.
    - Load with MEM_TYPE=1: go to DATA.
- **DATA** (BRAM only)
  - No strobes.
  - When `dmem_stall` is low: capture extended `dmem_rdata` and go to RESP.
  - When `dmem_stall` is high: hold.
- **RESP**
  - `rsp_valid` is 1 and the response is held stable.
  - On `rsp_ready`, go to IDLE.
  - A new request is accepted no earlier than the following cycle.
- **Address**: `dmem_raddr`/`dmem_waddr` = {`addr[31:2]`, 2'b00}. The unused address output is 0.
- **Stores**
  - SB: wstrb = 4'b0001<<`addr[1:0]`, wdata = byte×4.
  - SH: wstrb = 4'b0011<<(2·`addr[1]`), wdata = half×2.
  - SW: wstrb = 4'b1111.
  - Other funct3 values are an error.
- **Loads**
  - LB (000) and LBU (100) extract byte lane `addr[1:0]`. LB sign-extends, LBU zero-extends.
  - LH (001) and LHU (101) extract half lane `addr[1]`. LH sign-extends, LHU zero-extends.
  - LW (010) takes the full word.
  - 011, 110 and 111 are errors.
- **Reset**
  - State goes to IDLE.
  - `req_ready`=0 while `reset` is high.
  - All other outputs are 0.
  - Reset mid-operation abandons the access. No strobe appears in the cycle after reset is sampled.

## Timing
- Request accepted at cycle T:
  - Strobe at T+1.
  - `rsp_valid` at T+2 for a store or SRAM load; T+3 for a BRAM load.
  - Each `dmem_stall` cycle adds 1 cycle.
- Error response: `rsp_valid` at T+1.
- Strobes are single-cycle when there is no stall. No back-to-back requests: throughput is at most 1 per 3 cycles.
- Simultaneous `dmem_stall` and the first strobe cycle: the strobe repeats next cycle. The responder samples only the non-stalled strobe.

## Configuration
- `SVC_RV_DMEM_MISALIGN_EN` defined:
  - LH/LHU/SH with `addr[0]`=1, and LW/SW with `addr[1:0]`≠0, produce `rsp_err`=1.
  - No bus strobe is issued for these accesses.
- Undefined:
  - No misalign error.
  - Halfword ops use lane `addr[1]`.
  - Word ops ignore `addr[1:0]`.
  - Only illegal funct3 raises `rsp_err`.

## Structure
- Package `svc_rv_dmem_pkg` holds:
  - the funct3 localparams (LB..SW);
  - the `state_t` enum;
  - the `wstrb_gen` function.
- Sub-module `svc_rv_ld_ext` (combinational) takes rdata, funct3 and `addr[1:0]` and produces the extended 32-bit value.

## Test plan
- SRAM LW at 0x100, `dmem_rdata`=0xDEADBEEF, no stall → `dmem_ren` at T+1 with `raddr` 0x100; `rsp_valid` at T+2 with `rsp_rdata` 0xDEADBEEF.
- BRAM LB at 0x103, rdata 0x80_00_00_00 → `rsp_rdata` 0xFFFFFF80 at T+3; LBU on the same access → 0x00000080.
- SH at 0x102, wdata 0x1234 → `dmem_we` with `waddr` 0x100, `wstrb` 4'b1100, `wdata` 0x12341234.
- SW with `dmem_stall` high for 2 cycles → strobe held 3 cycles, `rsp_valid` at T+4; `rsp_ready` low for 2 cycles → response held unchanged.
- LW at 0x101:
  - MISALIGN_EN defined → `rsp_err`=1 at T+1, no `dmem_ren`.
  - Undefined → `raddr` 0x100, normal response.
- `reset` asserted during ACCESS of a BRAM load → next cycle all strobes 0, `rsp_valid` 0; the first request after reset completes normally.
